fetch_decode_reg: RTL and testbench

FETCH_DECODE_REG -- requirements
Module: fetch_decode_reg

---
 rtl/fetch_decode_reg.sv | 143 ++++++++++++++
 tb/tb_fetch_decode_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_reg.sv
// ============================================================================
//  Module   : fetch_decode_reg
//  Purpose  : Instruction fetch PC with a fetch/decode pipeline register,
//             stall, branch redirect and halt-opcode detection.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_decode_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [4:0]  HALT_OP  = 5'b11111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] InstrAddr,
    output logic        InstrRdEn,
    input  logic [31:0] InstrData,
    output logic [0:31] Instruction,
    output logic [31:0] PcID,
    output logic        ValidID,
    output logic [4:0]  OpCode,
    output logic [4:0]  InstructionP1,
    output logic [9:0]  InstructionP2,
    output logic        Halted
);

    localparam logic [1:0] S_START = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pcf_q,   pcf_d;
    logic        fv_q,    fv_d;
    logic [0:31] instr_q, instr_d;
    logic [31:0] pcid_q,  pcid_d;
    logic        vid_q,   vid_d;

    logic        halt_hit;
    logic [31:0] pc_next_seq;

    assign halt_hit    = vid_q && (instr_q[0:4] == HALT_OP);
    assign pc_next_seq = pc_q + PC_STEP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pcf_d   = pcf_q;
        fv_d    = fv_q;
        instr_d = instr_q;
        pcid_d  = pcid_q;
        vid_d   = vid_q;

        if (BranchTaken) begin
            // Redirect wins over stall and halt; the word in flight is stale.
            state_d = S_RUN;
            pc_d    = BranchTarget;
            fv_d    = 1'b0;
            instr_d = '0;
            pcid_d  = '0;
            vid_d   = 1'b0;
        end else begin
            case (state_q)
                S_START: begin
                    // Memory output is not yet valid, so the ID register stays empty.
                    state_d = S_RUN;
                    if (!Stall) begin
                        pc_d  = pc_next_seq;
                        pcf_d = pc_q;
                        fv_d  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (!Stall) begin
                        if (halt_hit) begin
                            state_d = S_HALT;
                            fv_d    = 1'b0;
                            instr_d = '0;
                            pcid_d  = '0;
                            vid_d   = 1'b0;
                        end else begin
                            pc_d  = pc_next_seq;
                            pcf_d = pc_q;
                            fv_d  = 1'b1;
                            if (fv_q) begin
                                instr_d = InstrData;
                                pcid_d  = pcf_q;
                                vid_d   = 1'b1;
                            end else begin
                                instr_d = '0;
                                pcid_d  = '0;
                                vid_d   = 1'b0;
                            end
                        end
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            pcf_q   <= '0;
            fv_q    <= 1'b0;
            instr_q <= '0;
            pcid_q  <= '0;
            vid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcf_q   <= pcf_d;
            fv_q    <= fv_d;
            instr_q <= instr_d;
            pcid_q  <= pcid_d;
            vid_q   <= vid_d;
        end
    end

    assign InstrAddr     = pc_q;
    assign InstrRdEn     = (state_q != S_HALT) && !Stall;
    assign Instruction   = instr_q;
    assign PcID          = pcid_q;
    assign ValidID       = vid_q;
    assign OpCode        = instr_q[0:4];
    assign InstructionP1 = instr_q[27:31];
    assign InstructionP2 = instr_q[22:31];
    assign Halted        = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_reg.sv
// ============================================================================
//  Module   : tb_fetch_decode_reg
//  Purpose  : Directed self-checking bench for fetch_decode_reg.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_decode_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InstrAddr;
    logic        InstrRdEn;
    logic [31:0] InstrData = '0;
    logic [0:31] Instruction;
    logic [31:0] PcID;
    logic        ValidID;
    logic [4:0]  OpCode;
    logic [4:0]  InstructionP1;
    logic [9:0]  InstructionP2;
    logic        Halted;

    int n_total = 0;
    int n_bad   = 0;

    fetch_decode_reg dut (
        .clk           (clk),
        .rst           (rst),
        .Stall         (Stall),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .InstrAddr     (InstrAddr),
        .InstrRdEn     (InstrRdEn),
        .InstrData     (InstrData),
        .Instruction   (Instruction),
        .PcID          (PcID),
        .ValidID       (ValidID),
        .OpCode        (OpCode),
        .InstructionP1 (InstructionP1),
        .InstructionP2 (InstructionP2),
        .Halted        (Halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: one-cycle latency, holds when not enabled.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd20) return 32'hF800_03FF;
        return 32'h1000_0000 + a;
    endfunction

    always @(posedge clk) begin
        if (InstrRdEn) InstrData <= mem_word(InstrAddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},  InstrAddr, 32'h0);
        chk({tag, "_vid"},   {31'd0, ValidID}, 32'd0);
        chk({tag, "_instr"}, Instruction, 32'h0);
        chk({tag, "_op"},    {27'd0, OpCode}, 32'd0);
        chk({tag, "_p1"},    {27'd0, InstructionP1}, 32'd0);
        chk({tag, "_p2"},    {22'd0, InstructionP2}, 32'd0);
        chk({tag, "_halt"},  {31'd0, Halted}, 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        tick(); tick();
        chk_reset("rst_hold");
        rst = 1'b0;
        #1 chk_reset("rst_rel");

        // Pipeline fill: first valid ID word on the third cycle.
        tick();
        chk("fill_vid0", {31'd0, ValidID}, 32'd0);
        chk("fill_addr4", InstrAddr, 32'd4);
        tick();
        chk("fill_vid1", {31'd0, ValidID}, 32'd1);
        chk("fill_pc0", PcID, 32'd0);
        chk("fill_ins0", Instruction, 32'h1000_0000);
        tick();
        chk("seq_pc4", PcID, 32'd4);
        tick();
        chk("seq_pc8", PcID, 32'd8);

        // Stall three cycles with PcID=8.
        Stall = 1'b1;
        #1 chk("stall_rden", {31'd0, InstrRdEn}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pcid", PcID, 32'd8);
            chk("stall_ins", Instruction, 32'h1000_0008);
            chk("stall_addr", InstrAddr, 32'd16);
        end
        Stall = 1'b0;
        tick();
        chk("unstall_pc12", PcID, 32'd12);
        chk("unstall_ins12", Instruction, 32'h1000_000C);
        tick();
        chk("seq_pc16", PcID, 32'd16);

        // Halt word at address 20.
        tick();
        chk("halt_pcid", PcID, 32'd20);
        chk("halt_op", {27'd0, OpCode}, 32'h1F);
        chk("halt_p1", {27'd0, InstructionP1}, 32'h1F);
        chk("halt_p2", {22'd0, InstructionP2}, 32'h3FF);
        chk("halt_pre", {31'd0, Halted}, 32'd0);
        tick();
        chk("halted", {31'd0, Halted}, 32'd1);
        chk("halted_vid", {31'd0, ValidID}, 32'd0);
        chk("halted_rden", {31'd0, InstrRdEn}, 32'd0);
        chk("halted_addr", InstrAddr, 32'd28);
        tick();
        chk("halted_hold", {31'd0, Halted}, 32'd1);
        chk("halted_addr2", InstrAddr, 32'd28);

        // Exit HALT via redirect to 0.
        BranchTaken = 1'b1; BranchTarget = 32'h0;
        tick();
        BranchTaken = 1'b0;
        chk("unhalt", {31'd0, Halted}, 32'd0);
        chk("unhalt_addr", InstrAddr, 32'd0);
        chk("unhalt_vid", {31'd0, ValidID}, 32'd0);
        tick();
        chk("unhalt_vid2", {31'd0, ValidID}, 32'd0);
        tick();
        chk("refetch_vid", {31'd0, ValidID}, 32'd1);
        chk("refetch_pc", PcID, 32'd0);

        // Redirect while stalled.
        Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h100;
        tick();
        Stall = 1'b0; BranchTaken = 1'b0;
        chk("br_addr", InstrAddr, 32'h100);
        chk("br_vid0", {31'd0, ValidID}, 32'd0);
        tick();
        chk("br_vid1", {31'd0, ValidID}, 32'd0);
        tick();
        chk("br_vid2", {31'd0, ValidID}, 32'd1);
        chk("br_pc", PcID, 32'h100);
        chk("br_ins", Instruction, 32'h1000_0100);

        // PC wrap.
        BranchTaken = 1'b1; BranchTarget = 32'hFFFF_FFFC;
        tick();
        BranchTaken = 1'b0;
        chk("wrap_addr0", InstrAddr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", InstrAddr, 32'h0);
        tick();
        chk("wrap_pcid", PcID, 32'hFFFF_FFFC);
        chk("wrap_ins", Instruction, 32'h0FFF_FFFC);

        // Reset during stall.
        Stall = 1'b1; rst = 1'b1;
        tick();
        chk_reset("rst_stall");
        rst = 1'b0; Stall = 1'b0;

        // Run to the halt word again, then defer halting with a stall.
        for (int i = 0; i < 30 && !(ValidID && PcID == 32'd20); i++) tick();
        chk("reach_halt", {31'd0, (ValidID && PcID == 32'd20)}, 32'd1);
        Stall = 1'b1;
        tick();
        chk("defer_halt", {31'd0, Halted}, 32'd0);
        chk("defer_pcid", PcID, 32'd20);
        Stall = 1'b0;
        tick();
        chk("defer_done", {31'd0, Halted}, 32'd1);

        // Reset in HALT.
        rst = 1'b1;
        tick();
        chk_reset("rst_halt");
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
